i2s_playback_24: RTL and testbench
==================================

Name: i2s_playback_24

Overview:
- 24-bit I2S transmitter, the playback counterpart of the I2S capture path.
- Serialises one stereo sample pair per frame onto `sd_o` for an external I2S DAC/codec.
- Runs as a follower to the `sck`/`ws` pair produced by the existing I2S clock generator, sampled in the system clock domain.
- Sits downstream of a sample source (RAM reader or DSP) through a valid/ready handshake with a one-frame holding buffer.

Parameters:
- DATA_W, 24, sample width in bits, sent MSB first.
- SLOT_W, 32, SCK periods per channel slot; the bits after DATA_W are zero padding.
- CNT_W, 16, width of the saturating underrun counter.

Ports:
- clk_i  input  1  system clock; `sck_i`/`ws_i` are generated synchronously to it.
- rst_i  input  1  synchronous active-high reset.
- sck_i  input  1  I2S bit clock from the clock generator; no resynchronisation required.
- ws_i  input  1  I2S word select: 0 = left slot, 1 = right slot; changes in the same clk cycle that `sck_i` falls.
- left_i  input  DATA_W  left sample, two's complement.
- right_i  input  DATA_W  right sample, two's complement.
- valid_i  input  1  sample pair valid.
- ready_o  output  1  holding buffer empty; transfer occurs when `valid_i` & `ready_o`.
- sd_o  output  1  I2S serial data, updated only on SCK falling edges.
- frame_start_o  output  1  one-clk pulse when a left slot is loaded.
- underrun_o  output  1  one-clk pulse when a frame starts with the holding buffer empty.
- underrun_cnt_o  output  CNT_W  saturating count of underruns.

Behaviour:
- Reset values:
  - `sd_o` = 0, `ready_o` = 1, `frame_start_o` = 0, `underrun_o` = 0, `underrun_cnt_o` = 0.
  - Shift register, right latch and holding buffer cleared.
  - `ws_prev` = 0; state = UNSYNC.
- Edge detection:
  - `sck_q` is registered each clk.
  - `fall` = `sck_q` & ~`sck_i`.
  - All slot logic advances only on cycles where `fall` = 1.
  - `ws_prev` <= `ws_i` on every `fall`.
- UNSYNC state:
  - `sd_o` is held at 0.
  - On a `fall` with `ws_prev` = 1 and `ws_i` = 0 (true left-slot start), go to RUN and perform a left load.
  - Guarantees no partial frame after reset.
- RUN state, on each `fall`:
  - Left edge (`ws_prev` = 1, `ws_i` = 0):
    - `sd_o` <= 0 (last pad bit of the previous slot).
    - If the holding buffer is full: shift register <= {hold_left, zeros}, right latch <= hold_right, holding buffer marked empty.
    - If the holding buffer is empty: shift register and right latch <= 0, pulse `underrun_o`, increment the counter saturating at 2^CNT_W-1.
    - `frame_start_o` pulses in the same clk cycle.
  - Right edge (`ws_prev` = 0, `ws_i` = 1): `sd_o` <= 0; shift register <= {right latch, zeros}.
  - No edge: `sd_o` <= shift register MSB; shift register <<= 1, zero fill.
- Resulting I2S timing:
  - The sample MSB appears on the SCK fall after the WS transition (standard one-bit delay).
  - DATA_W data bits are followed by zeros until the next WS edge.
  - Slots longer or shorter than SLOT_W are tolerated: the output is zero-filled or truncated.
- Handshake:
  - `ready_o` = ~hold_full.
  - A transfer sets hold_full on the next clk and captures `left_i`/`right_i`.
  - The source may hold `valid_i` high; data is sampled only on transfer.
- Simultaneous transfer and left load with the buffer empty:
  - The frame underruns (zeros are sent, `underrun_o` pulses).
  - The new pair is captured into the holding buffer and used at the next frame.
- Simultaneous transfer and left load with the buffer full: cannot occur, since `ready_o` = 0.
- Latency: from a transfer to its MSB on `sd_o` is at most 1 frame plus 1 SCK period.
- Reset mid-frame: the next clk returns to the reset values and UNSYNC; the current frame is abandoned.

Test Plan:
- Reset, then run the clock generator with no `valid_i`:
  - `sd_o` stays 0 throughout.
  - `underrun_o` pulses once per frame after the first left edge.
  - `underrun_cnt_o` = 3 after 3 frames.
- Push L = 0xA5C3F1, R = 0x123456 before a frame:
  - A bench I2S decoder recovers L = 0xA5C3F1 and R = 0x123456.
  - Bits 25–32 of each slot are 0.
  - The MSB lands exactly 1 SCK after each WS edge.
- Stream 8 pairs with `valid_i` held high:
  - `ready_o` drops after each transfer and rises on each `frame_start_o`.
  - All 8 pairs come out in order with zero underruns.
- Assert `valid_i` in the exact clk cycle of the left-edge `fall` with the buffer empty:
  - That frame is zeros and `underrun_o` pulses.
  - The pair appears in the next frame.
- Assert reset during bit 10 of the right slot:
  - `sd_o` = 0 and `ready_o` = 1 the next clk.
  - No output until the next 1->0 WS edge.
  - The following frame is correct.
- Force 1000 underruns with CNT_W = 8: `underrun_cnt_o` saturates at 255.

Source files
------------

// File: rtl/i2s_playback_24.sv
// I2S playback transmitter: follows an external sck/ws pair in the clk domain and
// serialises one buffered stereo pair per frame onto sd_o, MSB first, one bit after WS.
module i2s_playback_24 #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sck_i,
    input  logic                     ws_i,
    input  logic signed [DATA_W-1:0] left_i,
    input  logic signed [DATA_W-1:0] right_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic                     sd_o,
    output logic                     frame_start_o,
    output logic                     underrun_o,
    output logic [CNT_W-1:0]         underrun_cnt_o
);

    localparam int PAD_W = SLOT_W - DATA_W;

    typedef enum logic {
        ST_UNSYNC,
        ST_RUN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                     sck_p0;
    logic                     ws_prev;
    logic                     fall;
    logic                     left_edge;
    logic                     right_edge;
    logic                     do_left;
    logic                     do_right;
    logic                     do_shift;
    logic                     xfer;

    logic [SLOT_W-1:0]        shreg;
    logic signed [DATA_W-1:0] rlatch;
    logic signed [DATA_W-1:0] hold_left;
    logic signed [DATA_W-1:0] hold_right;
    logic                     hold_full;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign fall       = sck_p0 & ~sck_i;
    assign left_edge  = fall & ws_prev & ~ws_i;
    assign right_edge = fall & ~ws_prev & ws_i;
    assign ready_o    = ~hold_full;
    assign xfer       = valid_i & ready_o;

    // sck tracks even through reset so the first cycle after reset never sees a false fall
    always_ff @(posedge clk_i) begin
        sck_p0 <= sck_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_UNSYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Only a true 1->0 WS edge takes us out of UNSYNC, so no partial frame is ever sent
    always_comb begin
        state_d  = state_q;
        do_left  = 1'b0;
        do_right = 1'b0;
        do_shift = 1'b0;
        case (state_q)
            ST_UNSYNC: begin
                if (left_edge) begin
                    state_d = ST_RUN;
                    do_left = 1'b1;
                end
            end
            ST_RUN: begin
                if (left_edge) begin
                    do_left = 1'b1;
                end else if (right_edge) begin
                    do_right = 1'b1;
                end else if (fall) begin
                    do_shift = 1'b1;
                end
            end
            default: state_d = ST_UNSYNC;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ws_prev        <= 1'b0;
            sd_o           <= 1'b0;
            frame_start_o  <= 1'b0;
            underrun_o     <= 1'b0;
            underrun_cnt_o <= '0;
            shreg          <= '0;
            rlatch         <= '0;
            hold_left      <= '0;
            hold_right     <= '0;
            hold_full      <= 1'b0;
        end else begin
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
            if (fall) begin
                ws_prev <= ws_i;
            end

            // The WS-edge bit is the previous slot's last pad bit; data starts one SCK later
            if (do_left) begin
                sd_o          <= 1'b0;
                frame_start_o <= 1'b1;
                if (hold_full) begin
                    shreg  <= {hold_left, {PAD_W{1'b0}}};
                    rlatch <= hold_right;
                end else begin
                    shreg          <= '0;
                    rlatch         <= '0;
                    underrun_o     <= 1'b1;
                    underrun_cnt_o <= sat_inc(underrun_cnt_o);
                end
            end else if (do_right) begin
                sd_o  <= 1'b0;
                shreg <= {rlatch, {PAD_W{1'b0}}};
            end else if (do_shift) begin
                sd_o  <= shreg[SLOT_W-1];
                shreg <= {shreg[SLOT_W-2:0], 1'b0};
            end

            // A transfer landing on an underrun left load is kept for the following frame
            if (xfer) begin
                hold_left  <= left_i;
                hold_right <= right_i;
                hold_full  <= 1'b1;
            end else if (do_left) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_playback_24.sv
// Bench for i2s_playback_24: drives an sck/ws generator, decodes sd_o slot by slot,
// and checks recovered frames, handshake, underrun pulses and counter saturation.
module tb_i2s_playback_24;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        ws;
    logic [23:0] left_s;
    logic [23:0] right_s;
    logic        valid;
    logic        ready_o;
    logic        sd_o;
    logic        frame_start_o;
    logic        underrun_o;
    logic [15:0] cnt;
    logic        ready8;
    logic        sd8;
    logic        fs8;
    logic        ur8;
    logic [7:0]  cnt8;

    always #5 clk = ~clk;

    i2s_playback_24 dut (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws),
        .left_i(left_s), .right_i(right_s), .valid_i(valid),
        .ready_o(ready_o), .sd_o(sd_o), .frame_start_o(frame_start_o),
        .underrun_o(underrun_o), .underrun_cnt_o(cnt)
    );

    i2s_playback_24 #(.CNT_W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws),
        .left_i(left_s), .right_i(right_s), .valid_i(valid),
        .ready_o(ready8), .sd_o(sd8), .frame_start_o(fs8),
        .underrun_o(ur8), .underrun_cnt_o(cnt8)
    );

    // I2S generator and slot decoder: one SCK = 4 clk, ws changes with the sck fall,
    // sd_o is sampled at each sck rise; bit k of a slot is the k-th SCK after the WS edge.
    int          ph = 0;
    int          bitidx = 60;
    int          slot_len = 32;
    int          sd_ones = 0;
    int          urun_seen = 0;
    logic [63:0] rx[$];
    logic [63:0] cur = '0;

    initial begin
        int k;
        sck = 1'b1;
        ws  = 1'b1;
        forever begin
            @(negedge clk);
            if (sd_o === 1'b1) sd_ones++;
            if (underrun_o === 1'b1) urun_seen++;
            ph = (ph + 1) % 4;
            if (ph == 2) begin
                sck = 1'b0;
                bitidx = (bitidx + 1 >= 2 * slot_len) ? 0 : bitidx + 1;
                if (bitidx == 0 || bitidx == slot_len) begin
                    rx.push_back(cur);
                    cur = '0;
                end
                ws = (bitidx >= slot_len);
            end else if (ph == 0) begin
                sck = 1'b1;
                k = bitidx - (ws ? slot_len : 0);
                if (k >= 0 && k < 64) cur[k] = sd_o;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ok(input string tag, input bit ok, input int g);
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL %s: observed no event after %0d cycles, expected one", tag, g);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input string tag);
        int g = 0;
        do begin
            step();
            g++;
        end while (frame_start_o !== 1'b1 && g < 1000);
        chk_ok(tag, frame_start_o === 1'b1, g);
    endtask

    task automatic wait_rx(input string tag, input int n);
        int g = 0;
        while (rx.size() < n && g < 4000) begin
            step();
            g++;
        end
        chk_ok(tag, rx.size() >= n, g);
    endtask

    function automatic logic [23:0] slot_data(input logic [63:0] s);
        logic [23:0] d;
        for (int i = 0; i < 24; i++) d[23-i] = s[1+i];
        return d;
    endfunction

    // Consumes the frame whose frame_start is pending now or next, and decodes both slots
    task automatic expect_frame(input string tag, input logic [23:0] el, input logic [23:0] er,
                                input logic eur);
        logic [63:0] sl;
        logic [63:0] sr;
        int g = 0;
        while (frame_start_o !== 1'b1 && g < 1000) begin
            step();
            g++;
        end
        chk_ok({tag, "_fs"}, frame_start_o === 1'b1, g);
        chk({tag, "_ur"}, underrun_o, eur);
        rx.delete();
        wait_rx({tag, "_rx"}, 2);
        sl = rx.pop_front();
        sr = rx.pop_front();
        chk({tag, "_L"}, slot_data(sl), el);
        chk({tag, "_R"}, slot_data(sr), er);
        chk({tag, "_padL"}, {sl[31:25], sl[0]}, 0);
        chk({tag, "_padR"}, {sr[31:25], sr[0]}, 0);
    endtask

    initial begin
        logic [23:0] sl_a[8];
        logic [23:0] sr_a[8];
        logic [23:0] xl, xr, yl, yr, zl, zr;
        logic [15:0] c0;
        logic [63:0] s;
        logic        rdy;
        int          n, g, s0, u0;

        rst = 1'b1; valid = 1'b0; left_s = '0; right_s = '0;
        repeat (3) step();
        chk("rst_sd", sd_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_fs", frame_start_o, 0);
        chk("rst_ur", underrun_o, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_cnt8", cnt8, 0);
        rst = 1'b0;

        // idle: no source data, every frame underruns and sd_o stays low
        s0 = sd_ones; u0 = urun_seen;
        repeat (3) wait_fs("idle_fs");
        chk("idle_cnt", cnt, 3);
        chk("idle_cnt8", cnt8, 3);
        step();
        chk("idle_pulses", urun_seen - u0, 3);
        chk("idle_sd", sd_ones - s0, 0);

        // single directed pair
        left_s = 24'hA5C3F1; right_s = 24'h123456; valid = 1'b1;
        step();
        valid = 1'b0;
        chk("push_rdy", ready_o, 0);
        expect_frame("pair", 24'hA5C3F1, 24'h123456, 1'b0);

        // stream 8 random pairs with valid held high
        for (int i = 0; i < 8; i++) begin
            sl_a[i] = 24'($urandom);
            sr_a[i] = 24'($urandom);
        end
        c0 = cnt;
        rx.delete();
        left_s = sl_a[0]; right_s = sr_a[0]; valid = 1'b1;
        n = 0; g = 0;
        while (n < 8 && g < 4000) begin
            rdy = ready_o;
            step();
            g++;
            if (rdy) begin
                chk("stream_rdy_drop", ready_o, 0);
                n++;
                if (n < 8) begin
                    left_s = sl_a[n]; right_s = sr_a[n];
                end else begin
                    valid = 1'b0;
                end
            end
            if (frame_start_o === 1'b1) chk("stream_rdy_rise", ready_o, 1);
        end
        valid = 1'b0;
        chk_ok("stream_xfers", n == 8, g);
        wait_fs("stream_last_fs");
        chk("stream_ur", underrun_o, 0);
        chk("stream_cnt", cnt, c0);
        wait_rx("stream_rx", 18);
        s = rx.pop_front();
        s = rx.pop_front();
        for (int i = 0; i < 8; i++) begin
            s = rx.pop_front();
            chk($sformatf("stream_L%0d", i), slot_data(s), sl_a[i]);
            chk($sformatf("stream_padL%0d", i), {s[31:25], s[0]}, 0);
            s = rx.pop_front();
            chk($sformatf("stream_R%0d", i), slot_data(s), sr_a[i]);
        end

        // transfer in the very clk of the left-edge fall with an empty buffer
        g = 0;
        while (!(ph == 1 && bitidx == 2 * slot_len - 1) && g < 1000) begin
            step();
            g++;
        end
        chk_ok("late_align", ph == 1 && bitidx == 2 * slot_len - 1, g);
        xl = 24'($urandom); xr = 24'($urandom);
        left_s = xl; right_s = xr; valid = 1'b1;
        step();
        valid = 1'b0;
        chk("late_fs", frame_start_o, 1);
        chk("late_ur", underrun_o, 1);
        chk("late_rdy", ready_o, 0);
        rx.delete();
        wait_rx("late_rx", 2);
        chk("late_zeroL", slot_data(rx.pop_front()), 0);
        chk("late_zeroR", slot_data(rx.pop_front()), 0);
        expect_frame("late_pair", xl, xr, 1'b0);

        // reset during bit 10 of the right slot, then resync on the next left edge
        yl = 24'($urandom); yr = 24'($urandom);
        left_s = yl; right_s = yr; valid = 1'b1;
        step();
        valid = 1'b0;
        wait_fs("y_fs");
        g = 0;
        while (bitidx != slot_len + 10 && g < 1000) begin
            step();
            g++;
        end
        chk_ok("mid_align", bitidx == slot_len + 10, g);
        rst = 1'b1;
        step();
        chk("mid_sd", sd_o, 0);
        chk("mid_ready", ready_o, 1);
        chk("mid_cnt", cnt, 0);
        rst = 1'b0;
        s0 = sd_ones;
        zl = 24'($urandom) | 24'h800001; zr = 24'($urandom) | 24'h800001;
        left_s = zl; right_s = zr; valid = 1'b1;
        step();
        valid = 1'b0;
        chk("resync_push_rdy", ready_o, 0);
        g = 0;
        while (frame_start_o !== 1'b1 && g < 1000) begin
            step();
            g++;
        end
        chk_ok("resync_fs", frame_start_o === 1'b1, g);
        chk("resync_quiet", sd_ones - s0, 0);
        expect_frame("resync", zl, zr, 1'b0);

        // 1000 underruns on short slots: 8-bit counter saturates, 16-bit keeps counting
        slot_len = 2;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) wait_fs("sat_fs");
        chk("sat_cnt8", cnt8, 255);
        chk("sat_cnt16", cnt, 1000);
        rx.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
